// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo counter family.
// Holds the run-state enum and the saturating clip used on loads.
package mod_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clamp v into 0..mod-1; values at or above mod saturate to mod-1.
    function automatic logic [31:0] clip(
        input logic [31:0] v,
        input logic [31:0] mod
    );
        return (v >= mod) ? (mod - 32'd1) : v;
    endfunction

endpackage

// File: rtl/mod_down_timer.sv
// Modulo-MOD down timer with start/stop/load control and auto-reload.
// Ports: clk, reset (async, active high), en, start, stop, load,
//   load_val[N-1:0], oneshot (only with MOD_DOWN_ONESHOT_EN),
//   Q[N-1:0] count, tc terminal-count pulse, busy (state == RUN).
// Define MOD_DOWN_ONESHOT_EN to add the oneshot port: when high the
//   timer parks at 0 in IDLE after its first terminal count.
module mod_down_timer
    import mod_counter_pkg::*;
#(
    parameter int          N   = 3,
    parameter int unsigned MOD = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic         stop,
    input  logic         load,
    input  logic [N-1:0] load_val,
`ifdef MOD_DOWN_ONESHOT_EN
    input  logic         oneshot,
`endif
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         busy
);

    localparam logic [N-1:0] MAX = N'(MOD - 32'd1);

    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic [N-1:0] ld_clip;

    assign ld_clip = N'(clip(32'(load_val), 32'(MOD)));

    // Priority: stop > load > start > count. stop and load may both
    // take effect in one cycle (stop sets state, load sets Q).
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = 1'b0;
        if (stop) begin
            state_d = IDLE;
            if (load) begin
                q_d = ld_clip;
            end
        end else if (load) begin
            q_d = ld_clip;
        end else if (start) begin
            q_d     = MAX;
            state_d = RUN;
        end else if (state_q == RUN && en) begin
            if (q_q != '0) begin
                q_d = q_q - N'(1);
            end else begin
                tc_d = 1'b1;
`ifdef MOD_DOWN_ONESHOT_EN
                if (oneshot) begin
                    state_d = IDLE;
                end else begin
                    q_d = MAX;
                end
`else
                q_d = MAX;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
        end
    end

    assign Q    = q_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mod_down_timer.sv
// Directed testbench for mod_down_timer (N=3, MOD=6).
// Each task drives one scenario and checks Q/tc/busy inline.
module tb_mod_down_timer;

    logic       clk;
    logic       reset;
    logic       en;
    logic       start;
    logic       stop;
    logic       load;
    logic [2:0] load_val;
`ifdef MOD_DOWN_ONESHOT_EN
    logic       oneshot;
`endif
    logic [2:0] Q;
    logic       tc;
    logic       busy;

    int tests;
    int fails;

    mod_down_timer #(.N(3), .MOD(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
`ifdef MOD_DOWN_ONESHOT_EN
        .oneshot  (oneshot),
`endif
        .Q        (Q),
        .tc       (tc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (Q !== 3'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset: Q=%0d tc=%b busy=%b want Q=0 tc=0 busy=0",
                     Q, tc, busy);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (Q !== 3'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: Q=%0d busy=%b want Q=0 busy=0",
                     Q, busy);
        end
    endtask

    task automatic test_count();
        logic [2:0] eq [8];
        eq = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4};
        en    = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            tests++;
            if (Q !== eq[i] || tc !== (i == 6) || busy !== 1'b1) begin
                fails++;
                $display("FAIL count[%0d]: Q=%0d tc=%b busy=%b want Q=%0d tc=%b busy=1",
                         i, Q, tc, busy, eq[i], (i == 6));
            end
        end
    endtask

    task automatic test_load();
        load     = 1'b1;
        load_val = 3'd7;
        tick();
        tests++;
        if (Q !== 3'd5 || tc !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL load_sat: Q=%0d tc=%b busy=%b want Q=5 tc=0 busy=1",
                     Q, tc, busy);
        end
        load_val = 3'd2;
        tick();
        load = 1'b0;
        tests++;
        if (Q !== 3'd2 || tc !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL load_2: Q=%0d tc=%b busy=%b want Q=2 tc=0 busy=1",
                     Q, tc, busy);
        end
    endtask

    task automatic test_en_hold();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (Q !== 3'd2 || tc !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL en_hold[%0d]: Q=%0d tc=%b busy=%b want Q=2 tc=0 busy=1",
                         i, Q, tc, busy);
            end
        end
    endtask

    task automatic test_priority();
        stop     = 1'b1;
        load     = 1'b1;
        start    = 1'b1;
        load_val = 3'd3;
        tick();
        stop  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        tests++;
        if (Q !== 3'd3 || tc !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL priority: Q=%0d tc=%b busy=%b want Q=3 tc=0 busy=0",
                     Q, tc, busy);
        end
        en = 1'b1;
        tick();
        tests++;
        if (Q !== 3'd3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: Q=%0d busy=%b want Q=3 busy=0", Q, busy);
        end
    endtask

    task automatic test_restart();
        en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (Q !== 3'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_pre: Q=%0d busy=%b want Q=0 busy=1", Q, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (Q !== 3'd5 || tc !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart: Q=%0d tc=%b busy=%b want Q=5 tc=0 busy=1",
                     Q, tc, busy);
        end
    endtask

    task automatic test_stop();
        en = 1'b1;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests++;
        if (Q !== 3'd4 || tc !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stop: Q=%0d tc=%b busy=%b want Q=4 tc=0 busy=0",
                     Q, tc, busy);
        end
        tick();
        tests++;
        if (Q !== 3'd4 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stop_hold: Q=%0d busy=%b want Q=4 busy=0", Q, busy);
        end
    endtask

    task automatic test_reset_mid();
        en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tests++;
        if (Q !== 3'd3 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: Q=%0d busy=%b want Q=3 busy=1", Q, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (Q !== 3'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: Q=%0d tc=%b busy=%b want Q=0 tc=0 busy=0",
                     Q, tc, busy);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (Q !== 3'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL mid_idle[%0d]: Q=%0d tc=%b busy=%b want Q=0 tc=0 busy=0",
                         i, Q, tc, busy);
            end
        end
    endtask

`ifdef MOD_DOWN_ONESHOT_EN
    task automatic test_oneshot();
        logic [2:0] eq [6];
        eq      = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        oneshot = 1'b1;
        en      = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            tests++;
            if (Q !== eq[i] || tc !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL oneshot[%0d]: Q=%0d tc=%b busy=%b want Q=%0d tc=0 busy=1",
                         i, Q, tc, busy, eq[i]);
            end
        end
        tick();
        tests++;
        if (Q !== 3'd0 || tc !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_tc: Q=%0d tc=%b busy=%b want Q=0 tc=1 busy=0",
                     Q, tc, busy);
        end
        tick();
        tests++;
        if (Q !== 3'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_park: Q=%0d tc=%b busy=%b want Q=0 tc=0 busy=0",
                     Q, tc, busy);
        end
        oneshot = 1'b0;
    endtask
`endif

    initial begin
        tests    = 0;
        fails    = 0;
        en       = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        load     = 1'b0;
        load_val = 3'd0;
`ifdef MOD_DOWN_ONESHOT_EN
        oneshot  = 1'b0;
`endif
        test_reset();
        test_count();
        test_load();
        test_en_hold();
        test_priority();
        test_restart();
        test_stop();
        test_reset_mid();
`ifdef MOD_DOWN_ONESHOT_EN
        test_oneshot();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
